// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//
// Reset and lock sequencer for the on-chip PLL clock tree, clocked by the PLL
// reference clock. Holds the PLL in reset for a fixed window, waits for lock,
// requires lock to stay up for a settle window, then releases the system reset.
// Lock loss in RUN re-sequences the PLL. Failed attempts (lock timeout or a drop
// while settling) are counted, and reaching MAX_RETRY parks the block in FAIL
// until restart or reset.
//
// Optional feature macro: PLL_LOCK_FILTER_EN
//   defined   - in SETTLE and RUN a lock drop counts only after lock_s has been
//               low for 4 consecutive cycles.
//   undefined - any single low cycle of lock_s counts as a drop.
//
// Ports:
//   refclk     in   reference clock, the only clock of the block
//   reset      in   asynchronous active-high reset
//   pll_lock   in   PLL lock indication, asynchronous to refclk
//   restart    in   one-cycle synchronous request to re-run the sequence
//   pll_rst    out  drives the PLL reset pin
//   sys_rst    out  active-high reset for logic on the PLL output clock
//   ready      out  high in RUN only
//   fail       out  high in FAIL only
//   retry_cnt  out  failed attempts since the last restart or RUN entry
// -----------------------------------------------------------------------------
module pll_reset_seq #(
   parameter int RST_CYCLES    = 24,
   parameter int LOCK_TIMEOUT  = 24000,
   parameter int SETTLE_CYCLES = 2400,
   parameter int MAX_RETRY     = 3
) (
   input  logic       refclk,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       restart,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_cnt
);

   // One down-counter serves every timed state, sized for the longest window.
   localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_P  = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
   localparam int CNT_W  = $clog2(MAX_P) + 1;

   localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_SETTLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx_s;
   logic [3:0]       retry_nx_s;
   logic [3:0]       retry_inc_s;
   logic             sync_meta_r;
   logic             lock_s;
   logic             lock_drop_s;
   logic             cnt_zero_s;

   // Two-flop synchronizer bringing pll_lock into the refclk domain.
   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         sync_meta_r <= 1'b0;
         lock_s      <= 1'b0;
      end else begin
         sync_meta_r <= pll_lock;
         lock_s      <= sync_meta_r;
      end
   end

`ifdef PLL_LOCK_FILTER_EN
   logic [1:0] flt_cnt_r;

   // Consecutive low-lock cycle counter for SETTLE/RUN, saturating at 3.
   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         flt_cnt_r <= 2'd0;
      end else if (((state_r == S_SETTLE) || (state_r == S_RUN)) && !lock_s) begin
         if (flt_cnt_r != 2'd3) begin
            flt_cnt_r <= flt_cnt_r + 2'd1;
         end else begin
            flt_cnt_r <= flt_cnt_r;
         end
      end else begin
         flt_cnt_r <= 2'd0;
      end
   end

   // Three low cycles already counted plus the current one make four.
   assign lock_drop_s = !lock_s && (flt_cnt_r == 2'd3);
`else
   assign lock_drop_s = !lock_s;
`endif

   assign cnt_zero_s  = (cnt_r == CNT_ZERO);
   // Saturating increment; FAIL is entered when MAX_RETRY is reached, so the
   // hold branch only guards against an out-of-range parameter.
   assign retry_inc_s = (retry_cnt == RETRY_MAX) ? retry_cnt : (retry_cnt + 4'd1);

   // Next-state, counter and retry computation; restart overrides everything.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      retry_nx_s = retry_cnt;
      if (restart) begin
         state_nx_s = S_RESET_PLL;
         cnt_nx_s   = RST_LOAD;
         retry_nx_s = 4'd0;
      end else begin
         case (state_r)
            S_RESET_PLL: begin
               if (cnt_zero_s) begin
                  state_nx_s = S_WAIT_LOCK;
                  cnt_nx_s   = LOCK_LOAD;
               end else begin
                  cnt_nx_s = cnt_r - CNT_ONE;
               end
            end
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state_nx_s = S_SETTLE;
                  cnt_nx_s   = SETTLE_LOAD;
               end else if (cnt_zero_s) begin
                  retry_nx_s = retry_inc_s;
                  state_nx_s = (retry_inc_s == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
                  cnt_nx_s   = RST_LOAD;
               end else begin
                  cnt_nx_s = cnt_r - CNT_ONE;
               end
            end
            S_SETTLE: begin
               if (lock_drop_s) begin
                  retry_nx_s = retry_inc_s;
                  state_nx_s = (retry_inc_s == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
                  cnt_nx_s   = RST_LOAD;
               end else if (cnt_zero_s) begin
                  state_nx_s = S_RUN;
                  retry_nx_s = 4'd0;
               end else begin
                  cnt_nx_s = cnt_r - CNT_ONE;
               end
            end
            S_RUN: begin
               // Lock loss here re-sequences without counting as a failure.
               if (lock_drop_s) begin
                  state_nx_s = S_RESET_PLL;
                  cnt_nx_s   = RST_LOAD;
               end else begin
                  state_nx_s = S_RUN;
               end
            end
            S_FAIL: begin
               state_nx_s = S_FAIL;
            end
            default: begin
               state_nx_s = S_RESET_PLL;
               cnt_nx_s   = RST_LOAD;
               retry_nx_s = 4'd0;
            end
         endcase
      end
   end

   // State, counter, retry count and outputs decoded from the next state.
   always_ff @(posedge refclk or posedge reset) begin
      if (reset) begin
         state_r   <= S_RESET_PLL;
         cnt_r     <= RST_LOAD;
         retry_cnt <= 4'd0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         cnt_r     <= cnt_nx_s;
         retry_cnt <= retry_nx_s;
         pll_rst   <= (state_nx_s == S_RESET_PLL) || (state_nx_s == S_FAIL);
         sys_rst   <= (state_nx_s != S_RUN);
         ready     <= (state_nx_s == S_RUN);
         fail      <= (state_nx_s == S_FAIL);
      end
   end

endmodule

// File: tb/tb_pll_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_seq
//
// Self-checking bench for pll_reset_seq with RST_CYCLES=4, LOCK_TIMEOUT=20,
// SETTLE_CYCLES=8, MAX_RETRY=2. Each scenario task queues the output vector
// {pll_rst, sys_rst, ready, fail, retry_cnt[3:0]} it expects at given cycle
// numbers, then steps the clock and compares whenever a queued cycle comes up.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_seq;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int SETTLE_CYCLES = 8;
   localparam int MAX_RETRY     = 2;

`ifdef PLL_LOCK_FILTER_EN
   localparam int LOSS_LAT = 6;
   localparam bit FILT     = 1'b1;
`else
   localparam int LOSS_LAT = 3;
   localparam bit FILT     = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [7:0] val;
      int         tag;
   } exp_t;

   logic       refclk;
   logic       reset;
   logic       pll_lock;
   logic       restart;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [3:0] retry_cnt;
   logic [7:0] obs;

   exp_t exp_q[$];
   int   cyc;
   int   n_checks;
   int   n_fail;

   assign obs = {pll_rst, sys_rst, ready, fail, retry_cnt};

   pll_reset_seq #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .MAX_RETRY    (MAX_RETRY)
   ) dut (
      .refclk   (refclk),
      .reset    (reset),
      .pll_lock (pll_lock),
      .restart  (restart),
      .pll_rst  (pll_rst),
      .sys_rst  (sys_rst),
      .ready    (ready),
      .fail     (fail),
      .retry_cnt(retry_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Expected output vectors per state class.
   function automatic logic [7:0] o_rst(input logic [3:0] r);
      return {4'b1100, r};
   endfunction
   function automatic logic [7:0] o_wait(input logic [3:0] r);
      return {4'b0100, r};
   endfunction
   function automatic logic [7:0] o_run();
      return {4'b0010, 4'd0};
   endfunction
   function automatic logic [7:0] o_fail(input logic [3:0] r);
      return {4'b1101, r};
   endfunction

   function automatic void expect_at(input int c, input logic [7:0] v, input int tag);
      exp_t e;
      e.cyc = c;
      e.val = v;
      e.tag = tag;
      exp_q.push_back(e);
   endfunction

   task automatic step();
      @(posedge refclk);
      cyc = cyc + 1;
      @(negedge refclk);
   endtask

   task automatic test_reset();
      exp_t e;
      reset    = 1'b1;
      pll_lock = 1'b0;
      restart  = 1'b0;
      expect_at(cyc + 2, o_rst(4'd0), 1);
      for (int i = 0; i < 3; i++) begin
         step();
         while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL reset chk%0d cyc=%0d got=%b expected=%b", e.tag, cyc, obs, e.val);
            end
         end
      end
      reset = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset leftover got=%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_bringup();
      exp_t e;
      int   t0;
      int   p;
      t0 = cyc;
      p  = t0 + 10;
      expect_at(t0 + 3,  o_rst(4'd0),  1);
      expect_at(t0 + 4,  o_wait(4'd0), 2);
      expect_at(p + 2,   o_wait(4'd0), 3);
      expect_at(p + 10,  o_wait(4'd0), 4);
      expect_at(p + 11,  o_run(),      5);
      for (int i = 0; i < 25; i++) begin
         step();
         while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL bringup chk%0d cyc=%0d got=%b expected=%b", e.tag, cyc, obs, e.val);
            end
         end
         if (cyc == p) pll_lock = 1'b1;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bringup leftover got=%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_run_loss();
      exp_t e;
      int   k;
      k = cyc;
      pll_lock = 1'b0;
      expect_at(k + LOSS_LAT - 1,  o_run(),      1);
      expect_at(k + LOSS_LAT,      o_rst(4'd0),  2);
      expect_at(k + LOSS_LAT + 3,  o_rst(4'd0),  3);
      expect_at(k + LOSS_LAT + 4,  o_wait(4'd0), 4);
      expect_at(k + LOSS_LAT + 12, o_wait(4'd0), 5);
      expect_at(k + LOSS_LAT + 13, o_run(),      6);
      for (int i = 0; i < LOSS_LAT + 15; i++) begin
         step();
         while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL run_loss chk%0d cyc=%0d got=%b expected=%b", e.tag, cyc, obs, e.val);
            end
         end
         if (cyc == k + LOSS_LAT + 2) pll_lock = 1'b1;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL run_loss leftover got=%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_settle_glitch();
      exp_t e;
      int   k;
      k = cyc;
      restart = 1'b1;
      expect_at(k + 1, o_rst(4'd0),  1);
      expect_at(k + 5, o_wait(4'd0), 2);
      if (FILT) begin
         expect_at(k + 10, o_wait(4'd0), 3);
         expect_at(k + 13, o_wait(4'd0), 4);
         expect_at(k + 14, o_run(),      5);
         expect_at(k + 25, o_run(),      6);
      end else begin
         expect_at(k + 9,  o_wait(4'd0), 3);
         expect_at(k + 10, o_rst(4'd1),  4);
         expect_at(k + 13, o_rst(4'd1),  5);
         expect_at(k + 14, o_wait(4'd1), 6);
         expect_at(k + 22, o_wait(4'd1), 7);
         expect_at(k + 23, o_run(),      8);
      end
      for (int i = 0; i < 25; i++) begin
         step();
         while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL settle_glitch chk%0d cyc=%0d got=%b expected=%b", e.tag, cyc, obs, e.val);
            end
         end
         if (cyc == k + 1) restart = 1'b0;
         if (cyc == k + 7) pll_lock = 1'b0;
         if (cyc == k + 8) pll_lock = 1'b1;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL settle_glitch leftover got=%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   k;
      k = cyc;
      restart  = 1'b1;
      pll_lock = 1'b0;
      expect_at(k + 1,  o_rst(4'd0),  1);
      expect_at(k + 5,  o_wait(4'd0), 2);
      expect_at(k + 24, o_wait(4'd0), 3);
      expect_at(k + 25, o_rst(4'd1),  4);
      expect_at(k + 29, o_wait(4'd1), 5);
      expect_at(k + 33, o_wait(4'd1), 6);
      for (int i = 0; i < 33; i++) begin
         step();
         while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL reset_mid chk%0d cyc=%0d got=%b expected=%b", e.tag, cyc, obs, e.val);
            end
         end
         if (cyc == k + 1) restart = 1'b0;
         if (cyc == k + 29) pll_lock = 1'b1;
      end
      // Now in SETTLE with retry_cnt=1; reset between clock edges.
      #2;
      reset = 1'b1;
      #1;
      expect_at(cyc, o_rst(4'd0), 7);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL reset_mid chk%0d async got=%b expected=%b", e.tag, obs, e.val);
      end
      pll_lock = 1'b0;
      expect_at(cyc + 2, o_rst(4'd0), 8);
      for (int i = 0; i < 2; i++) begin
         step();
         while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL reset_mid chk%0d cyc=%0d got=%b expected=%b", e.tag, cyc, obs, e.val);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_mid leftover got=%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_lock_never();
      exp_t e;
      int   r;
      reset = 1'b0;
      r = cyc;
      expect_at(r + 3,  o_rst(4'd0),  1);
      expect_at(r + 4,  o_wait(4'd0), 2);
      expect_at(r + 23, o_wait(4'd0), 3);
      expect_at(r + 24, o_rst(4'd1),  4);
      expect_at(r + 27, o_rst(4'd1),  5);
      expect_at(r + 28, o_wait(4'd1), 6);
      expect_at(r + 47, o_wait(4'd1), 7);
      expect_at(r + 48, o_fail(4'd2), 8);
      expect_at(r + 60, o_fail(4'd2), 9);
      for (int i = 0; i < 60; i++) begin
         step();
         while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL lock_never chk%0d cyc=%0d got=%b expected=%b", e.tag, cyc, obs, e.val);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL lock_never leftover got=%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_restart();
      exp_t e;
      int   f;
      f = cyc;
      restart = 1'b1;
      expect_at(f + 1,  o_rst(4'd0),  1);
      expect_at(f + 4,  o_rst(4'd0),  2);
      expect_at(f + 5,  o_wait(4'd0), 3);
      expect_at(f + 24, o_wait(4'd0), 4);
      expect_at(f + 25, o_rst(4'd0),  5);
      expect_at(f + 30, o_rst(4'd0),  6);
      expect_at(f + 31, o_wait(4'd0), 7);
      expect_at(f + 50, o_wait(4'd0), 8);
      expect_at(f + 51, o_rst(4'd1),  9);
      for (int i = 0; i < 52; i++) begin
         step();
         while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e.val) begin
               n_fail++;
               $display("FAIL restart chk%0d cyc=%0d got=%b expected=%b", e.tag, cyc, obs, e.val);
            end
         end
         if (cyc == f + 1)  restart = 1'b0;
         if (cyc == f + 24) restart = 1'b1;
         if (cyc == f + 25) restart = 1'b0;
         if (cyc == f + 26) restart = 1'b1;
         if (cyc == f + 27) restart = 1'b0;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL restart leftover got=%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      cyc      = 0;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      pll_lock = 1'b0;
      restart  = 1'b0;
      test_reset();
      test_bringup();
      test_run_loss();
      test_settle_glitch();
      test_reset_mid();
      test_lock_never();
      test_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
